lock_reg_arbiter: RTL and testbench

- Shared write controller for a bank of lockable data registers.
- N_REQ requesters compete for one write/lock port.
- Grants are round-robin. Each granted operation is either a data write or a sticky lock-set on one register.
- Lock enforcement is unconditional: no bypass input exists. Lock bits clear only on reset. Sits between bus-side requesters and the protected register bank.

---
 rtl/lock_reg_arbiter.sv | 124 ++++++++++++
 tb/tb_lock_reg_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lock_reg_arbiter.sv
// Round-robin write/lock controller for a bank of lockable data registers.
// Each requester may write a register or set its sticky lock bit; writes to locked registers are refused.
//
// state  | meaning
// IDLE   | waiting for a request; grants the next requester after the last one served
// COMMIT | applies the latched write or lock and raises done for the served requester
// RESP   | done/err visible to the requester; clears them on exit
module lock_reg_arbiter #(
  parameter int N_REQ = 3,
  parameter int NREG  = 3,
  parameter int DW    = 16,
  parameter int AW    = 2
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    req_lock,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]    done,
  output logic [N_REQ-1:0]    err,
  output logic                busy,
  output logic [NREG*DW-1:0]  Data_out,
  output logic [NREG-1:0]     lock_status
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                   state, state_nxt;
  logic [IDW-1:0]           last, gnt_id, op_id;
  logic                     gnt_valid;
  logic                     op_lock;
  logic [AW-1:0]            op_addr;
  logic [DW-1:0]            op_wdata;
  logic [NREG-1:0][DW-1:0]  regs;
  logic [NREG-1:0]          locks;
  logic [NREG-1:0]          addr_hit;
  logic                     addr_ok, op_err;

  // Scan downward so the candidate closest after `last` is the one that sticks.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % N_REQ]) begin
        gnt_valid = 1'b1;
        gnt_id    = IDW'((int'(last) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    addr_hit = '0;
    for (int r = 0; r < NREG; r++) begin
      addr_hit[r] = (op_addr == AW'(r));
    end
    addr_ok = |addr_hit;
    op_err  = !addr_ok || (!op_lock && |(addr_hit & locks));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_valid) state_nxt = COMMIT;
      COMMIT:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last     <= IDW'(N_REQ - 1);
      op_id    <= '0;
      op_lock  <= 1'b0;
      op_addr  <= '0;
      op_wdata <= '0;
      regs     <= '0;
      locks    <= '0;
      done     <= '0;
      err      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            op_id    <= gnt_id;
            last     <= gnt_id;
            op_lock  <= req_lock[gnt_id];
            op_addr  <= req_addr[int'(gnt_id)*AW +: AW];
            op_wdata <= req_wdata[int'(gnt_id)*DW +: DW];
          end
        end
        COMMIT: begin
          for (int r = 0; r < NREG; r++) begin
            if (addr_hit[r] && !op_err) begin
              if (op_lock) locks[r] <= 1'b1;
              else         regs[r]  <= op_wdata;
            end
          end
          done[op_id] <= 1'b1;
          err[op_id]  <= op_err;
        end
        RESP: begin
          done <= '0;
          err  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state == COMMIT) || (state == RESP);
  assign Data_out    = regs;
  assign lock_status = locks;

endmodule

// File: tb/tb_lock_reg_arbiter.sv
// Self-checking bench for lock_reg_arbiter: directed scenarios followed by random batches,
// checked against a transaction-level model of the register bank, lock bits and rotating priority.
module tb_lock_reg_arbiter;
  localparam int N_REQ = 3;
  localparam int NREG  = 3;
  localparam int DW    = 16;
  localparam int AW    = 2;

  logic                Clk = 1'b0;
  logic                reset;
  logic [N_REQ-1:0]    req, req_lock;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wdata;
  logic [N_REQ-1:0]    done, err;
  logic                busy;
  logic [NREG*DW-1:0]  Data_out;
  logic [NREG-1:0]     lock_status;

  lock_reg_arbiter #(.N_REQ(N_REQ), .NREG(NREG), .DW(DW), .AW(AW)) dut (
    .Clk(Clk), .reset(reset), .req(req), .req_lock(req_lock), .req_addr(req_addr),
    .req_wdata(req_wdata), .done(done), .err(err), .busy(busy), .Data_out(Data_out),
    .lock_status(lock_status)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int fails   = 0;

  // Reference model state
  logic [DW-1:0]   m_reg [NREG];
  logic [NREG-1:0] m_lock;
  int              m_last;

  // Per-requester operation for the next batch
  logic            t_lock  [N_REQ];
  logic [AW-1:0]   t_addr  [N_REQ];
  logic [DW-1:0]   t_wdata [N_REQ];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < NREG; r++) m_reg[r] = '0;
    m_lock = '0;
    m_last = N_REQ - 1;
  endfunction

  function automatic logic [NREG*DW-1:0] model_data();
    logic [NREG*DW-1:0] v;
    v = '0;
    for (int r = 0; r < NREG; r++) v[r*DW +: DW] = m_reg[r];
    return v;
  endfunction

  function automatic int model_pick(input logic [N_REQ-1:0] pend);
    for (int k = 1; k <= N_REQ; k++) begin
      automatic int i = (m_last + k) % N_REQ;
      if (pend[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic model_apply(input int id);
    automatic int a = int'(t_addr[id]);
    if (a >= NREG) return 1'b1;
    if (t_lock[id]) begin
      m_lock[a] = 1'b1;
      return 1'b0;
    end
    if (m_lock[a]) return 1'b1;
    m_reg[a] = t_wdata[id];
    return 1'b0;
  endfunction

  // Raise the requesters in mask together; each drops req once it sees its done.
  task automatic run_batch(input logic [N_REQ-1:0] mask);
    logic [N_REQ-1:0] pending;
    logic             e;
    int               id, cyc;
    bit               first;
    @(negedge Clk);
    for (int i = 0; i < N_REQ; i++) begin
      req_lock[i]               = t_lock[i];
      req_addr[i*AW +: AW]      = t_addr[i];
      req_wdata[i*DW +: DW]     = t_wdata[i];
    end
    req     = mask;
    pending = mask;
    first   = 1'b1;
    while (pending != '0) begin
      id     = model_pick(pending);
      m_last = id;
      e      = model_apply(id);
      cyc    = 0;
      do begin
        @(negedge Clk);
        cyc++;
      end while (done == '0 && cyc < 12);
      check("latency", 64'(cyc), first ? 64'd2 : 64'd3);
      check("done", 64'(done), 64'(N_REQ'(1) << id));
      check("err", 64'(err), e ? 64'(N_REQ'(1) << id) : 64'd0);
      check("busy_resp", 64'(busy), 64'd1);
      check("data_out", 64'(Data_out), 64'(model_data()));
      check("lock_status", 64'(lock_status), 64'(m_lock));
      if (done == '0) begin
        req     = '0;
        pending = '0;
      end else begin
        req[id]     = 1'b0;
        pending[id] = 1'b0;
      end
      first = 1'b0;
    end
  endtask

  function automatic void set_op(input int i, input logic lk, input int a, input logic [DW-1:0] d);
    t_lock[i]  = lk;
    t_addr[i]  = AW'(a);
    t_wdata[i] = d;
  endfunction

  initial begin
    reset     = 1'b1;
    req       = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < N_REQ; i++) set_op(i, 1'b0, 0, '0);
    model_reset();
    #1;
    check("rst_data", 64'(Data_out), 64'd0);
    check("rst_lock", 64'(lock_status), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge Clk);
    reset = 1'b0;

    // Plain write, then lock and rejected write to the same register
    set_op(0, 1'b0, 0, 16'hA5A5);
    run_batch(3'b001);
    check("wr_reg0", 64'(Data_out[15:0]), 64'h A5A5);
    set_op(1, 1'b1, 0, 16'h0000);
    run_batch(3'b010);
    check("lock_reg0", 64'(lock_status), 64'b001);
    set_op(2, 1'b0, 0, 16'h1234);
    run_batch(3'b100);
    check("rej_reg0", 64'(Data_out[15:0]), 64'h A5A5);
    set_op(2, 1'b0, 1, 16'h1234);
    run_batch(3'b100);
    check("wr_reg1", 64'(Data_out[31:16]), 64'h1234);

    // Invalid address from requester 0, then all three contend: expect 1,2,0
    set_op(0, 1'b0, 3, 16'hFFFF);
    run_batch(3'b001);
    check("bad_addr_data", 64'(Data_out), 64'h0000_1234_A5A5);
    set_op(0, 1'b0, 2, 16'h0C0C);
    set_op(1, 1'b0, 2, 16'h1C1C);
    set_op(2, 1'b0, 2, 16'h2C2C);
    run_batch(3'b111);
    check("rr_last_writer", 64'(Data_out[47:32]), 64'h0C0C);

    // Lock reg2, then reset during COMMIT of a write
    set_op(2, 1'b1, 2, 16'h0000);
    run_batch(3'b100);
    check("lock_reg2", 64'(lock_status[2]), 64'd1);
    @(negedge Clk);
    req_lock[0]     = 1'b0;
    req_addr[1:0]   = 2'd1;
    req_wdata[15:0] = 16'h7777;
    req             = 3'b001;
    @(negedge Clk);
    check("commit_busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_lock", 64'(lock_status), 64'd0);
    check("mid_rst_data", 64'(Data_out), 64'd0);
    model_reset();
    req = '0;
    @(negedge Clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      check("no_done_after_rst", 64'(done), 64'd0);
    end
    set_op(0, 1'b0, 2, 16'hBEEF);
    run_batch(3'b001);
    check("beef_reg2", 64'(Data_out[47:32]), 64'h BEEF);

    // Random contention
    repeat (40) begin
      for (int i = 0; i < N_REQ; i++) begin
        set_op(i, ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)), DW'($urandom));
      end
      run_batch(N_REQ'($urandom_range(1, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
